serial_rx16: RTL and testbench

// - Serial-to-parallel receiver: rebuilds a 16-bit word from a bit-serial stream, LSB first.
// - Receiving end of the serial link whose transmitter drives mux16 select lines from a 4-bit counter.
// - Each received bit goes to slot pdata[cnt]; cnt is a 4-bit bit counter.
// - The finished word is presented to the ALU operand path over a valid/ready handshake.

---
 rtl/serial_pkg.sv | 18 +
 rtl/rx_bit_counter.sv | 46 ++++
 rtl/serial_rx16.sv | 178 +++++++++++++++++
 tb/tb_serial_rx16.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// serial_pkg: types and constants shared by both ends of the bit-serial link.
//   rx_state_t - receiver FSM states (PAR is only reachable when the
//                SERIAL_RX16_PARITY_EN macro is defined).
//   SER_WIDTH  - word width carried by the link.
//   SER_CNT_W  - width of the bit counter that walks through the word.
package serial_pkg;

  localparam int SER_WIDTH = 16;
  localparam int SER_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2,
    DONE  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/rx_bit_counter.sv
// rx_bit_counter: bit-position counter for the serial receiver.
// Ports:
//   clk   in   rising-edge clock
//   rst_n in   synchronous active-low reset (counter returns to 0)
//   load  in   frame start: counter becomes 1 (bit 0 is written this cycle)
//   inc   in   advance to the next bit slot; wraps from all-ones to 0
//   cnt   out  current bit slot
//   last  out  high when cnt addresses the final slot
module rx_bit_counter
  import serial_pkg::*;
#(
  parameter int CNT_W = SER_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Load wins over increment: a frame restart must always land on slot 1.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CNT_W'(1);
    end else if (inc) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign last = (cnt_q == {CNT_W{1'b1}});

endmodule

// File: rtl/serial_rx16.sv
// serial_rx16: rebuilds a 16-bit word from an LSB-first bit-serial stream and
// offers it to the consumer over a valid/ready handshake.
// Ports:
//   clk, rst_n        clock and synchronous active-low reset
//   sdata, svalid     serial bit and its qualifier
//   sframe            with svalid: this bit is bit 0 of a new frame
//   pdata, pvalid     assembled word (held while pvalid) and its qualifier
//   pready            consumer accept; transfer on pvalid & pready
//   frame_err         1-cycle pulse: frame restarted before completion
//   overrun           1-cycle pulse: bit arrived while a word was pending
//   par_err           even-parity mismatch, valid with pvalid
// Configuration macro: SERIAL_RX16_PARITY_EN adds a parity bit after bit 15.
// Without it par_err is tied to 0.
// WIDTH must equal 2**CNT_W so the counter addresses every slot exactly once.
module serial_rx16
  import serial_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH,
  parameter int CNT_W = SER_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sdata,
  input  logic             svalid,
  input  logic             sframe,
  output logic [WIDTH-1:0] pdata,
  output logic             pvalid,
  input  logic             pready,
  output logic             frame_err,
  output logic             overrun,
  output logic             par_err
);

  rx_state_t        state_q, state_d;
  logic [WIDTH-1:0] pdata_q, pdata_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
`ifdef SERIAL_RX16_PARITY_EN
  logic             par_err_q, par_err_d;
`endif

  logic             cnt_load;
  logic             cnt_inc;
  logic             wr_en;
  logic [CNT_W-1:0] cnt;
  logic             cnt_last;
  logic [CNT_W-1:0] wr_sel;
  logic [WIDTH-1:0] slot_we;

  rx_bit_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .load (cnt_load),
    .inc  (cnt_inc),
    .cnt  (cnt),
    .last (cnt_last)
  );

  // Next-state logic. Every accepted data bit raises wr_en; a frame start
  // also raises cnt_load, which steers the write to slot 0.
  always_comb begin
    state_d     = state_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    cnt_load    = 1'b0;
    cnt_inc     = 1'b0;
    wr_en       = 1'b0;
`ifdef SERIAL_RX16_PARITY_EN
    par_err_d   = par_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (svalid && sframe) begin
          cnt_load = 1'b1;
          wr_en    = 1'b1;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (svalid) begin
          wr_en = 1'b1;
          if (sframe) begin
            cnt_load    = 1'b1;
            frame_err_d = 1'b1;
          end else begin
            cnt_inc = 1'b1;
            if (cnt_last) begin
`ifdef SERIAL_RX16_PARITY_EN
              state_d = PAR;
`else
              state_d = DONE;
`endif
            end
          end
        end
      end
`ifdef SERIAL_RX16_PARITY_EN
      PAR: begin
        if (svalid) begin
          if (sframe) begin
            cnt_load    = 1'b1;
            wr_en       = 1'b1;
            frame_err_d = 1'b1;
            state_d     = SHIFT;
          end else begin
            // Even parity: the XOR over all data bits plus the parity bit is 0.
            par_err_d = ^pdata_q ^ sdata;
            state_d   = DONE;
          end
        end
      end
`endif
      DONE: begin
        if (pready) begin
          state_d = IDLE;
`ifdef SERIAL_RX16_PARITY_EN
          par_err_d = 1'b0;
`endif
          // Back-to-back frames: a frame start in the handshake cycle is kept.
          if (svalid && sframe) begin
            cnt_load = 1'b1;
            wr_en    = 1'b1;
            state_d  = SHIFT;
          end
        end else if (svalid) begin
          overrun_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Slot write: decode the target slot into a one-hot write enable so only
  // the addressed bit of pdata changes; all other bits keep their value.
  always_comb begin
    wr_sel  = cnt_load ? '0 : cnt;
    slot_we = '0;
    if (wr_en) begin
      slot_we[wr_sel] = 1'b1;
    end
    for (int i = 0; i < WIDTH; i++) begin
      pdata_d[i] = slot_we[i] ? sdata : pdata_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pdata_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef SERIAL_RX16_PARITY_EN
      par_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pdata_q     <= pdata_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef SERIAL_RX16_PARITY_EN
      par_err_q   <= par_err_d;
`endif
    end
  end

  assign pdata     = pdata_q;
  assign pvalid    = (state_q == DONE);
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
`ifdef SERIAL_RX16_PARITY_EN
  assign par_err   = par_err_q;
`else
  assign par_err   = 1'b0;
`endif

endmodule

// File: tb/tb_serial_rx16.sv
// tb_serial_rx16: self-checking bench for serial_rx16.
// Define SERIAL_RX16_PARITY_EN to exercise the parity build.
module tb_serial_rx16;

  logic        clk;
  logic        rst_n;
  logic        sdata;
  logic        svalid;
  logic        sframe;
  logic [15:0] pdata;
  logic        pvalid;
  logic        pready;
  logic        frame_err;
  logic        overrun;
  logic        par_err;

  int errors;
  int checks;

  // Scoreboard: expected words are queued as frames are sent; the monitor
  // queues every word it sees transferred.
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  int          fe_cnt;
  int          ov_cnt;

  typedef struct {
    logic [15:0] word;
    int          gap;
    int          hold;
    logic [15:0] exp_word;
  } vec_t;

  vec_t vecs[4];

  serial_rx16 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sdata    (sdata),
    .svalid   (svalid),
    .sframe   (sframe),
    .pdata    (pdata),
    .pvalid   (pvalid),
    .pready   (pready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .par_err  (par_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (pvalid && pready) got_q.push_back(pdata);
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // One clock cycle of stimulus; inputs return to idle afterwards.
  task automatic applyStimulus(input logic v, input logic f, input logic d);
    svalid = v;
    sframe = f;
    sdata  = d;
    @(posedge clk);
    #1;
    svalid = 1'b0;
    sframe = 1'b0;
    sdata  = 1'b0;
  endtask

  // Sends a full frame LSB first with 'gap' idle cycles between bits.
  // ready_first holds pready high during bit 0 (back-to-back handshake).
  task automatic sendFrame(input logic [15:0] word, input int gap,
                           input logic ready_first, input logic par_bit);
    logic [15:0] w;
    w = word;
    for (int i = 0; i < 16; i++) begin
      pready = (i == 0) ? ready_first : 1'b0;
      applyStimulus(1'b1, i == 0, w[i]);
      pready = 1'b0;
      if (i < 15) repeat (gap) applyStimulus(1'b0, 1'b0, 1'b0);
    end
`ifdef SERIAL_RX16_PARITY_EN
    applyStimulus(1'b1, 1'b0, par_bit);
`else
    if (par_bit === 1'bx) $display("[TB] unexpected parity argument");
`endif
  endtask

  task automatic drainCheck(input string name);
    if (got_q.size() == 0) begin
      checkOutput({name, "_xfer_missing"}, 32'd0, 32'd1);
    end else if (exp_q.size() == 0) begin
      checkOutput({name, "_xfer_extra"}, 32'd1, 32'd0);
      void'(got_q.pop_front());
    end else begin
      checkOutput(name, {16'h0, got_q.pop_front()}, {16'h0, exp_q.pop_front()});
    end
  endtask

  // Completes the handshake of a pending word and compares it.
  task automatic doHandshake(input string name, input logic [15:0] expw);
    checkOutput({name, "_pvalid"}, {31'h0, pvalid}, 32'd1);
    checkOutput({name, "_pdata"}, {16'h0, pdata}, {16'h0, expw});
    pready = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    pready = 1'b0;
    checkOutput({name, "_pvalid_drop"}, {31'h0, pvalid}, 32'd0);
    drainCheck({name, "_sb"});
  endtask

  initial begin
    int fe0;
    int ov0;
    int nx0;
    logic [15:0] w;
    errors = 0;
    checks = 0;
    fe_cnt = 0;
    ov_cnt = 0;
    rst_n  = 1'b0;
    sdata  = 1'b0;
    svalid = 1'b0;
    sframe = 1'b0;
    pready = 1'b0;

    vecs[0] = '{word: 16'hA5C3, gap: 0, hold: 0, exp_word: 16'hA5C3};
    vecs[1] = '{word: 16'h00FF, gap: 3, hold: 5, exp_word: 16'h00FF};
    vecs[2] = '{word: 16'h5A5A, gap: 1, hold: 2, exp_word: 16'h5A5A};
    vecs[3] = '{word: 16'hFFFF, gap: 0, hold: 1, exp_word: 16'hFFFF};

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_pdata", {16'h0, pdata}, 32'd0);
    checkOutput("reset_pvalid", {31'h0, pvalid}, 32'd0);
    checkOutput("reset_flags", {29'h0, frame_err, overrun, par_err}, 32'd0);
    rst_n = 1'b1;

    // Table-driven frames.
    for (int k = 0; k < 4; k++) begin
      nx0 = got_q.size();
      exp_q.push_back(vecs[k].exp_word);
      sendFrame(vecs[k].word, vecs[k].gap, 1'b0, ^vecs[k].word);
      checkOutput($sformatf("vec%0d_latency", k), {31'h0, pvalid}, 32'd1);
      checkOutput($sformatf("vec%0d_par_err", k), {31'h0, par_err}, 32'd0);
      for (int h = 0; h < vecs[k].hold; h++) begin
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput($sformatf("vec%0d_hold%0d", k, h), {15'h0, pvalid, pdata},
                    {15'h0, 1'b1, vecs[k].exp_word});
      end
      checkOutput($sformatf("vec%0d_no_early_xfer", k), got_q.size(), nx0);
      doHandshake($sformatf("vec%0d", k), vecs[k].exp_word);
    end

    // Frame restart: eight bits of 0xFFFF, then a new frame 0x1234.
    fe0 = fe_cnt;
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, i == 0, 1'b1);
    exp_q.push_back(16'h1234);
    sendFrame(16'h1234, 0, 1'b0, ^16'h1234);
    checkOutput("abort_frame_err_count", fe_cnt - fe0, 32'd1);
    doHandshake("abort", 16'h1234);

    // Overrun: word pending, two extra bits with no handshake.
    ov0 = ov_cnt;
    exp_q.push_back(16'hBEEF);
    sendFrame(16'hBEEF, 0, 1'b0, ^16'hBEEF);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("overrun_count", ov_cnt - ov0, 32'd2);
    checkOutput("overrun_pdata", {16'h0, pdata}, 32'h0000BEEF);
    doHandshake("overrun", 16'hBEEF);

    // Back-to-back: handshake of 0x0001 together with bit 0 of 0x8000.
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    exp_q.push_back(16'h0001);
    sendFrame(16'h0001, 0, 1'b0, ^16'h0001);
    exp_q.push_back(16'h8000);
    sendFrame(16'h8000, 0, 1'b1, ^16'h8000);
    drainCheck("b2b_first_sb");
    doHandshake("b2b_second", 16'h8000);
    checkOutput("b2b_no_flags", (fe_cnt - fe0) + (ov_cnt - ov0), 32'd0);

    // Reset in the middle of a frame at bit 10.
    w = 16'h3C3C;
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, i == 0, w[i]);
    rst_n = 1'b0;
    applyStimulus(1'b1, 1'b0, w[10]);
    checkOutput("midrst_outputs", {12'h0, pdata, pvalid, frame_err, overrun, par_err},
                32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("midrst_ignore", {15'h0, pvalid, pdata}, 32'd0);
    exp_q.push_back(16'h5555);
    sendFrame(16'h5555, 0, 1'b0, ^16'h5555);
    doHandshake("midrst_frame", 16'h5555);

`ifdef SERIAL_RX16_PARITY_EN
    exp_q.push_back(16'h0003);
    sendFrame(16'h0003, 0, 1'b0, 1'b1);
    checkOutput("parity_err_set", {30'h0, pvalid, par_err}, 32'd3);
    doHandshake("parity_bad", 16'h0003);
    checkOutput("parity_err_clear", {31'h0, par_err}, 32'd0);
    exp_q.push_back(16'h0003);
    sendFrame(16'h0003, 0, 1'b0, 1'b0);
    checkOutput("parity_ok", {30'h0, pvalid, par_err}, 32'd2);
    doHandshake("parity_good", 16'h0003);
`endif

    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("sb_leftover", got_q.size() + exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
